stunir_job_dispatcher: RTL
==========================

Name: stunir_job_dispatcher

Overview:
- Upstream driver and downstream collector for one STUNIR generated compute module with a start/done/result interface.
- Accepts job requests on a valid/ready port and issues a single-cycle start pulse to the worker.
- Detects the worker's done rising edge, or a timeout, and captures the result.
- Queues completions in a small FIFO drained through a valid/ready output port, with completion and timeout counters for status.

Parameters:
- DATA_W, 32: width of worker result and out_data.
- ID_W, 4: width of job tag carried from request to completion.
- FIFO_DEPTH, 4: completion FIFO entries; power of 2, at least 2.
- TIMEOUT, 16: WAIT-state cycles before the job is abandoned; at least 4.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous reset, active-high.
- job_valid  in  1  job request valid.
- job_ready  out  1  dispatcher can accept a job.
- job_id  in  ID_W  tag for the request.
- wk_start  out  1  start pulse to the worker.
- wk_done  in  1  worker done; level, sticky until the next start.
- wk_result  in  DATA_W  worker result; valid when wk_done rises.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  consumer accepts the head entry.
- out_data  out  DATA_W  head entry result.
- out_id  out  ID_W  head entry tag.
- out_timeout  out  1  head entry was a timeout.
- busy  out  1  state != IDLE.
- jobs_done  out  16  count of successful completions; saturating.
- timeouts  out  16  count of timed-out jobs; saturating.

Behaviour:
- Reset, sampled at a clk edge with rst=1:
  - State goes to IDLE.
  - wk_start, busy, out_valid, out_data, out_id, out_timeout, jobs_done and timeouts all go to 0.
  - FIFO pointers are cleared and storage zeroed.
  - done_q is set to 0 and the timer to 0.
- Reset mid-job abandons the job: no FIFO entry is written and no counter changes. The worker is not reset by this block.
- done_q registers wk_done every cycle in every state. done_edge = wk_done & ~done_q.
- job_ready = (state==IDLE) & (FIFO count < FIFO_DEPTH), combinational from registers.
- IDLE: on job_valid & job_ready, latch job_id and go to ISSUE.
- ISSUE: the cycle spent in ISSUE drives wk_start=1 from a register. wk_start is 1 in exactly this one cycle per job. Clear the timer and go to WAIT.
- WAIT, priority order:
  - done_edge: capture wk_result, set tmo=0, go to PUSH.
  - Otherwise, if timer==TIMEOUT-1: set captured result=0, tmo=1, go to PUSH.
  - Otherwise: timer+1.
  - done_edge and timeout in the same cycle: done wins.
  - A stale wk_done=1 held from a previous job is not an edge. Completion requires a 0→1 transition seen while in WAIT.
- PUSH: write {tmo, id, result} to the FIFO tail and go to IDLE. A slot is guaranteed because fullness was checked at accept and only one job is ever in flight.
- Counters on each PUSH write:
  - jobs_done+1 if tmo=0; timeouts+1 if tmo=1.
  - Both saturate at 0xFFFF.
- FIFO:
  - Pop on out_valid & out_ready.
  - out_* show the head slot, registered storage with no combinational path from job inputs.
  - Simultaneous push and pop: count unchanged and both occur.
  - Pointers wrap modulo FIFO_DEPTH.
  - out_ready while empty has no effect.
- Latency with a standard worker (done 3 cycles after start), empty FIFO, out_ready=1, job accepted in cycle 0:
  - wk_start=1 in cycle 1.
  - wk_done rises in cycle 4.
  - PUSH in cycle 5.
  - out_valid=1 and job_ready=1 in cycle 6.
- Back-to-back jobs: the next accept can happen in cycle 6 at the earliest.
- job_valid while not ready is held off; the requester must keep job_valid and job_id stable.

Test Plan:
- Reset, then job_id=3 with a worker model returning 0xDEADBEEF → wk_start high for exactly cycle 1; out_valid in cycle 6 with out_data=0xDEADBEEF, out_id=3, out_timeout=0; jobs_done=1.
- Worker never raises done → after TIMEOUT=16 WAIT cycles the entry {out_timeout=1, out_data=0, out_id=tag} appears; timeouts=1; job_ready returns to 1.
- Stale done: wk_done held 1 from a prior job, worker drops it 1 cycle after start and raises it 3 cycles later → exactly one completion with the new result; no early capture.
- out_ready=0 with 5 jobs issued → 4 entries queued; job_ready stays 0 after the 4th PUSH. Then out_ready=1 → entries drain in order with tags 0,1,2,3, and the 5th job is accepted.
- done_edge on the same cycle as timer==TIMEOUT-1 → entry has out_timeout=0 with the real result; jobs_done increments and timeouts does not.
- rst=1 asserted during WAIT → next cycle state IDLE, wk_start=0, out_valid=0, counters 0; a later wk_done edge produces no entry.

Source files
------------

// File: rtl/stunir_job_dispatcher.sv
// Job dispatcher for one start/done/result compute worker.
// Accepts tagged job requests, pulses the worker's start, waits for the
// worker's done rising edge or a timeout, then queues the outcome in a
// small completion FIFO. Completion and timeout counters provide status.
module stunir_job_dispatcher #(
    parameter int DATA_W     = 32,
    parameter int ID_W       = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              job_valid,
    output logic              job_ready,
    input  logic [ID_W-1:0]   job_id,
    output logic              wk_start,
    input  logic              wk_done,
    input  logic [DATA_W-1:0] wk_result,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ID_W-1:0]   out_id,
    output logic              out_timeout,
    output logic              busy,
    output logic [15:0]       jobs_done,
    output logic [15:0]       timeouts
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [CNT_W-1:0] FIFO_FULL = CNT_W'(FIFO_DEPTH);
    localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_PUSH
    } state_t;

    // One completion record: timeout flag, job tag and captured result.
    typedef struct packed {
        logic              tmo;
        logic [ID_W-1:0]   id;
        logic [DATA_W-1:0] data;
    } entry_t;

    state_t            state, state_next;
    logic              done_q;
    logic              done_edge;
    logic [TMR_W-1:0]  timer;
    logic [ID_W-1:0]   id_q;
    logic [DATA_W-1:0] res_q;
    logic              tmo_q;

    logic              accept;
    logic              timer_clr;
    logic              timer_inc;
    logic              cap_done;
    logic              cap_tmo;
    logic              push;
    logic              pop;

    entry_t            fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;

    // A done level held over from the previous job never counts; only a
    // fresh 0->1 transition of wk_done marks completion.
    assign done_edge = wk_done & ~done_q;

    // Fullness is checked at accept; with one job in flight the PUSH slot
    // is then guaranteed.
    assign job_ready = (state == S_IDLE) && (count < FIFO_FULL);
    assign busy      = (state != S_IDLE);
    assign out_valid = (count != '0);
    assign pop       = out_valid & out_ready;

    assign out_data    = fifo_mem[rd_ptr].data;
    assign out_id      = fifo_mem[rd_ptr].id;
    assign out_timeout = fifo_mem[rd_ptr].tmo;

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    // Next-state and per-state control strobes.
    // NOTE: every output of this block gets a default first so no path
    // leaves a signal unassigned and a latch is never inferred.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        timer_clr  = 1'b0;
        timer_inc  = 1'b0;
        cap_done   = 1'b0;
        cap_tmo    = 1'b0;
        push       = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (job_valid && job_ready) begin
                    accept     = 1'b1;
                    state_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                timer_clr  = 1'b1;
                state_next = S_WAIT;
            end
            S_WAIT: begin
                // A done edge beats a timeout landing in the same cycle.
                if (done_edge) begin
                    cap_done   = 1'b1;
                    state_next = S_PUSH;
                end else if (timer == TMR_LAST) begin
                    cap_tmo    = 1'b1;
                    state_next = S_PUSH;
                end else begin
                    timer_inc  = 1'b1;
                end
            end
            S_PUSH: begin
                push       = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Job datapath: tag latch, start pulse, done history, timer, capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            done_q   <= 1'b0;
            wk_start <= 1'b0;
            timer    <= '0;
            id_q     <= '0;
            res_q    <= '0;
            tmo_q    <= 1'b0;
        end else begin
            done_q   <= wk_done;
            // Registered so the pulse covers exactly the ISSUE cycle.
            wk_start <= accept;
            if (accept) id_q <= job_id;
            if (timer_clr)      timer <= '0;
            else if (timer_inc) timer <= timer + 1'b1;
            if (cap_done) begin
                res_q <= wk_result;
                tmo_q <= 1'b0;
            end else if (cap_tmo) begin
                res_q <= '0;
                tmo_q <= 1'b1;
            end
        end
    end

    // Completion FIFO: storage, wrapping pointers and occupancy.
    // NOTE: the storage is cleared in reset so the head outputs read zero
    // straight after reset; that is why the array sits under the reset branch.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= '{tmo: tmo_q, id: id_q, data: res_q};
                wr_ptr           <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Saturating status counters, stepped on each FIFO write.
    always_ff @(posedge clk) begin
        if (rst) begin
            jobs_done <= '0;
            timeouts  <= '0;
        end else if (push) begin
            if (tmo_q) begin
                if (timeouts != 16'hFFFF) timeouts <= timeouts + 1'b1;
            end else begin
                if (jobs_done != 16'hFFFF) jobs_done <= jobs_done + 1'b1;
            end
        end
    end

endmodule
